// File: rtl/i2c_data_unit_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_data_unit_if : strobes from the I2C control unit and status back to it
// rev 1.0
// ----------------------------------------------------------------------------
interface i2c_data_unit_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
);
  logic                  BaudEnable;
  logic                  ReadorWrite;
  logic                  Select;
  logic                  ShiftorHold;
  logic                  StartStopAck;
  logic                  WriteLoad;
  logic [DATA_WIDTH-1:0] DataIn;
  logic [CNT_WIDTH-1:0]  BitCount;
  logic                  ByteSent;
  logic                  AckReceived;
  logic                  AckError;

  modport master (
    output BaudEnable, ReadorWrite, Select, ShiftorHold, StartStopAck, WriteLoad, DataIn,
    input  BitCount, ByteSent, AckReceived, AckError
  );

  modport slave (
    input  BaudEnable, ReadorWrite, Select, ShiftorHold, StartStopAck, WriteLoad, DataIn,
    output BitCount, ByteSent, AckReceived, AckError
  );
endinterface
`default_nettype wire

// File: rtl/i2c_data_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_data_unit : byte shifter and ACK sampler driving open-drain SDA/SCL
// rev 1.0
// ----------------------------------------------------------------------------
module i2c_data_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  wire logic      clock,
  input  wire logic      reset,
  input  wire logic      ClockI2C,
  i2c_data_unit_if.slave ctl,
  inout  wire            SDA,
  output logic           SCL
);
  localparam logic [CNT_WIDTH-1:0] C_LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

  logic                  clk_prev_q;
  logic [DATA_WIDTH-1:0] shift_reg_q, shift_reg_d;
  logic [CNT_WIDTH-1:0]  bit_count_q, bit_count_d;
  logic                  byte_sent_q, byte_sent_d;
  logic                  ack_received_q, ack_received_d;
  logic                  ack_error_q, ack_error_d;
  logic                  sda_low_q, sda_low_d;

  logic w_fall, w_rise, w_shift_en, w_sda_bit;

  assign w_fall = clk_prev_q & ~ClockI2C;
  assign w_rise = ~clk_prev_q & ClockI2C;
  // bit_count_q <= C_LAST_BIT is the "still below DATA_WIDTH" test, so no wrap
  assign w_shift_en = w_fall & ctl.ShiftorHold & ctl.BaudEnable & ~ctl.ReadorWrite &
                      (bit_count_q <= C_LAST_BIT);

  always_comb begin
    shift_reg_d    = shift_reg_q;
    bit_count_d    = bit_count_q;
    ack_error_d    = ack_error_q;
    byte_sent_d    = 1'b0;
    ack_received_d = 1'b0;
    if (ctl.WriteLoad) begin
      shift_reg_d = ctl.DataIn;
      bit_count_d = '0;
      ack_error_d = 1'b0;
    end else if (w_shift_en) begin
      shift_reg_d = {shift_reg_q[DATA_WIDTH-2:0], 1'b0};
      bit_count_d = bit_count_q + 1'b1;
      byte_sent_d = (bit_count_q == C_LAST_BIT);
    end else if (w_rise && ctl.ReadorWrite) begin
      ack_error_d    = SDA;
      ack_received_d = 1'b1;
    end
    // next shift_reg value is used so SDA tracks the bit being presented
    w_sda_bit = ctl.Select ? shift_reg_d[DATA_WIDTH-1] : ctl.StartStopAck;
    sda_low_d = ~ctl.ReadorWrite & ~w_sda_bit;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_prev_q     <= 1'b1;
      shift_reg_q    <= '0;
      bit_count_q    <= '0;
      byte_sent_q    <= 1'b0;
      ack_received_q <= 1'b0;
      ack_error_q    <= 1'b0;
      sda_low_q      <= 1'b0;
    end else begin
      clk_prev_q     <= ClockI2C;
      shift_reg_q    <= shift_reg_d;
      bit_count_q    <= bit_count_d;
      byte_sent_q    <= byte_sent_d;
      ack_received_q <= ack_received_d;
      ack_error_q    <= ack_error_d;
      sda_low_q      <= sda_low_d;
    end
  end

  assign SDA             = sda_low_q ? 1'b0 : 1'bz;
  assign SCL             = ctl.BaudEnable ? ClockI2C : 1'b1;
  assign ctl.BitCount    = bit_count_q;
  assign ctl.ByteSent    = byte_sent_q;
  assign ctl.AckReceived = ack_received_q;
  assign ctl.AckError    = ack_error_q;
endmodule
`default_nettype wire

// File: tb/tb_i2c_data_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_i2c_data_unit : directed self-checking bench for i2c_data_unit
// rev 1.0
// ----------------------------------------------------------------------------
module tb_i2c_data_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic clock_i2c = 1'b1;
  logic slave_low = 1'b0;
  logic scl;
  wire  sda;

  int checks = 0;
  int errors = 0;
  int bs_cnt = 0;
  int ar_cnt = 0;
  int bs0, ar0;
  logic [7:0] pattern;

  i2c_data_unit_if #(.DATA_WIDTH(8), .CNT_WIDTH(4)) bus ();

  i2c_data_unit #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .ClockI2C (clock_i2c),
    .ctl      (bus.slave),
    .SDA      (sda),
    .SCL      (scl)
  );

  pullup (sda);
  assign sda = slave_low ? 1'b0 : 1'bz;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (bus.ByteSent)    bs_cnt <= bs_cnt + 1;
    if (bus.AckReceived) ar_cnt <= ar_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic scl_period(input int half);
    clock_i2c = 1'b1;
    tick(half);
    clock_i2c = 1'b0;
    tick(half);
  endtask

  initial begin
    bus.BaudEnable   = 1'b0;
    bus.ReadorWrite  = 1'b0;
    bus.Select       = 1'b0;
    bus.ShiftorHold  = 1'b0;
    bus.StartStopAck = 1'b1;
    bus.WriteLoad    = 1'b0;
    bus.DataIn       = 8'h00;
    tick(3);
    reset = 1'b0;
    tick(2);

    // 1) reset state
    check("rst_sda", sda, 1'b1);
    check("rst_scl", scl, 1'b1);
    check("rst_bitcount", bus.BitCount, 4'd0);
    check("rst_ackerror", bus.AckError, 1'b0);
    check("rst_bytesent", bus.ByteSent, 1'b0);
    check("rst_ackrecv", bus.AckReceived, 1'b0);

    // 2) transmit 8'hA5
    bus.BaudEnable  = 1'b1;
    bus.Select      = 1'b1;
    bus.ShiftorHold = 1'b1;
    clock_i2c = 1'b0;
    tick(2);
    check("scl_follows_low", scl, 1'b0);
    bus.WriteLoad = 1'b1;
    bus.DataIn    = 8'hA5;
    tick(1);
    bus.WriteLoad = 1'b0;
    bs0 = bs_cnt;
    pattern = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      clock_i2c = 1'b1;
      tick(2);
      check("a5_bit", sda, pattern[7-i]);
      tick(2);
      clock_i2c = 1'b0;
      tick(4);
    end
    check("a5_bitcount", bus.BitCount, 4'd8);
    check("a5_bytesent_once", bs_cnt - bs0, 1);
    check("a5_sda_after", sda, 1'b0);

    // 3) ACK sampling
    ar0 = ar_cnt;
    bus.ReadorWrite = 1'b1;
    tick(1);
    check("read_sda_released", sda, 1'b1);
    slave_low = 1'b1;
    clock_i2c = 1'b1;
    tick(2);
    check("ack_error_ack", bus.AckError, 1'b0);
    check("ack_pulse1", ar_cnt - ar0, 1);
    check("ack_bitcount_kept", bus.BitCount, 4'd8);
    clock_i2c = 1'b0;
    tick(4);
    slave_low = 1'b0;
    clock_i2c = 1'b1;
    tick(2);
    check("ack_error_nack", bus.AckError, 1'b1);
    check("ack_pulse2", ar_cnt - ar0, 2);
    clock_i2c = 1'b0;
    tick(2);

    // 4) 10 falls after 8'hFF
    bus.ReadorWrite = 1'b0;
    bus.WriteLoad   = 1'b1;
    bus.DataIn      = 8'hFF;
    tick(1);
    bus.WriteLoad = 1'b0;
    check("ff_load_clears_ackerr", bus.AckError, 1'b0);
    bs0 = bs_cnt;
    for (int i = 0; i < 10; i++) begin
      clock_i2c = 1'b1;
      tick(2);
      if (i == 0) check("ff_first_bit", sda, 1'b1);
      clock_i2c = 1'b0;
      tick(2);
    end
    check("ff_bitcount_sat", bus.BitCount, 4'd8);
    check("ff_bytesent_once", bs_cnt - bs0, 1);
    bus.ReadorWrite = 1'b1;
    tick(1);
    check("ff_sda_released", sda, 1'b1);

    // 5) WriteLoad coincident with a fall
    bus.ReadorWrite = 1'b0;
    clock_i2c = 1'b1;
    tick(2);
    clock_i2c     = 1'b0;
    bus.WriteLoad = 1'b1;
    bus.DataIn    = 8'h5A;
    tick(1);
    bus.WriteLoad = 1'b0;
    tick(1);
    check("wl_fall_bitcount", bus.BitCount, 4'd0);
    check("wl_fall_msb", sda, 1'b0);
    scl_period(2);
    check("wl_then_shift_count", bus.BitCount, 4'd1);
    check("wl_then_shift_sda", sda, 1'b1);

    // 6) reset mid-byte of 8'h3C
    bus.WriteLoad = 1'b1;
    bus.DataIn    = 8'h3C;
    tick(1);
    bus.WriteLoad = 1'b0;
    for (int i = 0; i < 3; i++) scl_period(2);
    check("3c_bitcount", bus.BitCount, 4'd3);
    bus.Select       = 1'b0;
    bus.StartStopAck = 1'b0;
    tick(1);
    check("ssa_drive_low", sda, 1'b0);
    reset = 1'b1;
    #1;
    check("midrst_sda", sda, 1'b1);
    check("midrst_bitcount", bus.BitCount, 4'd0);
    check("midrst_ackerror", bus.AckError, 1'b0);
    check("midrst_bytesent", bus.ByteSent, 1'b0);
    tick(2);
    reset            = 1'b0;
    bus.Select       = 1'b1;
    bus.StartStopAck = 1'b1;
    tick(1);
    bus.WriteLoad = 1'b1;
    bus.DataIn    = 8'h3C;
    tick(1);
    bus.WriteLoad = 1'b0;
    tick(1);
    check("reload_bitcount", bus.BitCount, 4'd0);
    check("reload_bit7", sda, 1'b0);
    scl_period(2);
    scl_period(2);
    check("reload_bit5", sda, 1'b1);
    check("reload_bitcount2", bus.BitCount, 4'd2);

    // SCL released when baud disabled
    bus.BaudEnable = 1'b0;
    tick(1);
    check("scl_released", scl, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
